calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Instruction-driven controller for the two-stack calculation datapath.
- Accepts one instruction per valid/ready handshake and selects the target stack (T or E) through `cycle`.
- Drives single-clock stack strobes and tracks the depth of each stack.
- Traps overflow and underflow before any illegal strobe reaches the datapath.

Parameters:
- DEPTH, 6: stack depth of each shift register in the datapath.
- DW, $clog2(DEPTH+1): width of the depth counters (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instr_kind  in  2  00 PUSH, 01 LUT, 10 ACC, 11 END
- instr_tgt  in  1  target stack: 0=E, 1=T
- instr_op  in  2  operation code
- instr_lut  in  4  look-up table
- instr_val  in  1  operand value
- instr_pop  in  1  pop request (LUT/ACC)
- err_clr  in  1  leaves ERR state
- cycle  out  1  datapath phase; 1 makes T the written stack, 0 makes E the written stack
- lut  out  4  to datapath
- op  out  2  to datapath
- val  out  1  to datapath
- do_pop  out  1  to datapath
- en_push_force  out  1  to datapath
- en_pop  out  1  to datapath
- en_push  out  1  to datapath
- en_stack_wr  out  1  to datapath
- mux_sta  out  2  to datapath
- depth_t  out  DW  occupancy of stack T
- depth_e  out  DW  occupancy of stack E
- busy  out  1  state != IDLE
- done  out  1  one-clock pulse when END retires
- err_overflow  out  1  sticky error flag
- err_underflow  out  1  sticky error flag

Behaviour:
- All outputs are registered.
- Reset values: cycle=0, lut=0, op=0, val=0, mux_sta=00, all enable/pop strobes=0, depths=0, errors=0, done=0, busy=0, state=IDLE.
- FSM states: IDLE, ISSUE, HOLD, ERR.

FSM transitions:
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch the instruction, then check legality against the depth of the target stack (d).
  - Legal: go to ISSUE.
  - Illegal: go to ERR and set the matching sticky flag.
- ISSUE (exactly one clk):
  - cycle=instr_tgt; lut, op and val are driven from the latched fields.
  - Strobes are asserted per the kind table below.
  - The depth counter of the target stack updates at the end of this clk.
  - Next state is HOLD.
- HOLD (one clk): all strobes 0; cycle, lut, op and val are held. Next state is IDLE.
- ERR: instr_ready=0 and all strobes 0. Stays in ERR until err_clr=1, then goes to IDLE. Error flags are cleared only by reset.
- Throughput: one instruction per 3 clks. Acceptance to strobe latency is 1 clk.
- Between instructions, cycle, lut, op and val hold their last values; strobes are always 0 outside ISSUE.

Kind table (d = depth of the target stack):
- PUSH:
  - Strobes: en_push_force=1, en_stack_wr=1, mux_sta=00.
  - Depth: d+1.
  - Illegal if d==DEPTH (overflow).
- LUT:
  - Strobes: en_stack_wr=1, en_pop=1, do_pop=instr_pop, mux_sta=10.
  - Depth: d-1 if instr_pop, else unchanged.
  - Illegal if d==0 (underflow).
  - Illegal if instr_pop && d==1 (underflow).
- ACC:
  - Strobes: en_stack_wr=1, en_pop=1, en_push=1, do_pop=instr_pop, mux_sta=11.
  - Depth: d-1 if instr_pop, else d+1.
  - Illegal if d==0 (underflow).
  - Illegal if !instr_pop && d==DEPTH (overflow).
- END:
  - Strobes: none.
  - Depth: unchanged.
  - done pulses in the HOLD clk.

Boundary rules:
- An illegal instruction never produces a strobe, and neither depth counter changes.
- Depth arithmetic never wraps.
- reset low mid-instruction (ISSUE or HOLD) aborts the instruction: the next clk is IDLE with reset values, and no strobe is asserted on that edge.
- err_clr while not in ERR is ignored.
- instr_valid while instr_ready=0 is ignored; the instruction is not latched.

Test Plan:
- Reset, then PUSH tgt=1 val=1 → ISSUE clk shows cycle=1, en_push_force=1, en_stack_wr=1, mux_sta=00, val=1. Afterwards depth_t=1, depth_e=0; instr_ready is low for 2 clks.
- 6× PUSH tgt=0, then a 7th PUSH tgt=0 → depth_e=6, err_overflow=1, no strobe on the 7th, state ERR. After err_clr, instr_ready=1 and depth_e is still 6.
- After reset, LUT tgt=1 with depth_t=0 → err_underflow=1, all strobes stay 0. Separately, with depth_t=2, LUT pop=1 op=10 lut=0110 → do_pop=1, mux_sta=10, op=10, lut=0110, depth_t=1.
- With depth_e=3: ACC pop=0 → en_push=1, en_pop=1, do_pop=0, mux_sta=11, depth_e=4. Then ACC pop=1 → depth_e=3.
- END → done high for exactly 1 clk (the HOLD clk), no strobes, depths unchanged. Back-to-back valid instructions are accepted every 3rd clk.
- reset driven low during the ISSUE clk of a PUSH → next clk shows all outputs at reset values and depth 0, and no further strobe is emitted.

Source files
------------

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module   : calc_sequencer
// Brief    : Instruction sequencer for the two-stack calculation datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer #(
    parameter int DEPTH = 6,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [1:0]    instr_kind,
    input  logic          instr_tgt,
    input  logic [1:0]    instr_op,
    input  logic [3:0]    instr_lut,
    input  logic          instr_val,
    input  logic          instr_pop,
    input  logic          err_clr,
    output logic          cycle,
    output logic [3:0]    lut,
    output logic [1:0]    op,
    output logic          val,
    output logic          do_pop,
    output logic          en_push_force,
    output logic          en_pop,
    output logic          en_push,
    output logic          en_stack_wr,
    output logic [1:0]    mux_sta,
    output logic [DW-1:0] depth_t,
    output logic [DW-1:0] depth_e,
    output logic          busy,
    output logic          done,
    output logic          err_overflow,
    output logic          err_underflow
);

    localparam logic [1:0]    C_KIND_PUSH = 2'b00;
    localparam logic [1:0]    C_KIND_LUT  = 2'b01;
    localparam logic [1:0]    C_KIND_ACC  = 2'b10;
    localparam logic [1:0]    C_KIND_END  = 2'b11;
    localparam logic [DW-1:0] C_FULL      = DW'(DEPTH);
    localparam logic [DW-1:0] C_ONE       = DW'(1);
    localparam logic [DW-1:0] C_ZERO      = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_tgt;
    logic            r_end;
    logic [DW-1:0]   r_next_d;

    logic [DW-1:0]   w_d;
    logic [DW-1:0]   w_next_d;
    logic            w_ovf;
    logic            w_unf;

    assign w_d = instr_tgt ? depth_t : depth_e;

    // Legality and the post-instruction depth are judged on the offered
    // instruction, so an illegal one is trapped before any strobe is raised.
    always_comb begin
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_next_d = w_d;
        case (instr_kind)
            C_KIND_PUSH: begin
                w_ovf    = (w_d == C_FULL);
                w_next_d = w_d + C_ONE;
            end
            C_KIND_LUT: begin
                w_unf    = (w_d == C_ZERO) || (instr_pop && (w_d == C_ONE));
                w_next_d = instr_pop ? (w_d - C_ONE) : w_d;
            end
            C_KIND_ACC: begin
                w_unf    = (w_d == C_ZERO);
                w_ovf    = !instr_pop && (w_d == C_FULL);
                w_next_d = instr_pop ? (w_d - C_ONE) : (w_d + C_ONE);
            end
            default: begin
                w_next_d = w_d;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_tgt         <= 1'b0;
            r_end         <= 1'b0;
            r_next_d      <= '0;
            instr_ready   <= 1'b1;
            cycle         <= 1'b0;
            lut           <= 4'd0;
            op            <= 2'd0;
            val           <= 1'b0;
            do_pop        <= 1'b0;
            en_push_force <= 1'b0;
            en_pop        <= 1'b0;
            en_push       <= 1'b0;
            en_stack_wr   <= 1'b0;
            mux_sta       <= 2'b00;
            depth_t       <= '0;
            depth_e       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            // Strobes live for the ISSUE clock only; everything else holds.
            do_pop        <= 1'b0;
            en_push_force <= 1'b0;
            en_pop        <= 1'b0;
            en_push       <= 1'b0;
            en_stack_wr   <= 1'b0;
            mux_sta       <= 2'b00;
            done          <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        r_tgt       <= instr_tgt;
                        r_end       <= (instr_kind == C_KIND_END);
                        r_next_d    <= w_next_d;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (w_ovf || w_unf) begin
                            r_state       <= S_ERR;
                            err_overflow  <= err_overflow | w_ovf;
                            err_underflow <= err_underflow | w_unf;
                        end else begin
                            r_state <= S_ISSUE;
                            cycle   <= instr_tgt;
                            lut     <= instr_lut;
                            op      <= instr_op;
                            val     <= instr_val;
                            case (instr_kind)
                                C_KIND_PUSH: begin
                                    en_push_force <= 1'b1;
                                    en_stack_wr   <= 1'b1;
                                    mux_sta       <= 2'b00;
                                end
                                C_KIND_LUT: begin
                                    en_stack_wr <= 1'b1;
                                    en_pop      <= 1'b1;
                                    do_pop      <= instr_pop;
                                    mux_sta     <= 2'b10;
                                end
                                C_KIND_ACC: begin
                                    en_stack_wr <= 1'b1;
                                    en_pop      <= 1'b1;
                                    en_push     <= 1'b1;
                                    do_pop      <= instr_pop;
                                    mux_sta     <= 2'b11;
                                end
                                default: begin
                                    mux_sta <= 2'b00;
                                end
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_tgt) begin
                        depth_t <= r_next_d;
                    end else begin
                        depth_e <= r_next_d;
                    end
                    done    <= r_end;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    r_state     <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                S_ERR: begin
                    if (err_clr) begin
                        r_state     <= S_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Table-driven, scoreboarded bench for calc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

    localparam int DEPTH = 6;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [1:0] K_PUSH = 2'b00;
    localparam logic [1:0] K_LUT  = 2'b01;
    localparam logic [1:0] K_ACC  = 2'b10;
    localparam logic [1:0] K_END  = 2'b11;

    logic          clk;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_kind;
    logic          instr_tgt;
    logic [1:0]    instr_op;
    logic [3:0]    instr_lut;
    logic          instr_val;
    logic          instr_pop;
    logic          err_clr;
    logic          cycle;
    logic [3:0]    lut;
    logic [1:0]    op;
    logic          val;
    logic          do_pop;
    logic          en_push_force;
    logic          en_pop;
    logic          en_push;
    logic          en_stack_wr;
    logic [1:0]    mux_sta;
    logic [DW-1:0] depth_t;
    logic [DW-1:0] depth_e;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic          err_underflow;

    logic [4:0] strb;
    assign strb = {en_push_force, en_pop, en_push, en_stack_wr, do_pop};

    calc_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_kind   (instr_kind),
        .instr_tgt    (instr_tgt),
        .instr_op     (instr_op),
        .instr_lut    (instr_lut),
        .instr_val    (instr_val),
        .instr_pop    (instr_pop),
        .err_clr      (err_clr),
        .cycle        (cycle),
        .lut          (lut),
        .op           (op),
        .val          (val),
        .do_pop       (do_pop),
        .en_push_force(en_push_force),
        .en_pop       (en_pop),
        .en_push      (en_push),
        .en_stack_wr  (en_stack_wr),
        .mux_sta      (mux_sta),
        .depth_t      (depth_t),
        .depth_e      (depth_e),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strb order: {en_push_force, en_pop, en_push, en_stack_wr, do_pop}
    typedef struct packed {
        logic       pre_rst;
        logic [1:0] kind;
        logic       tgt;
        logic [1:0] opc;
        logic [3:0] lutv;
        logic       v;
        logic       pop;
        logic       legal;
        logic [4:0] strb;
        logic [1:0] mux;
        logic [3:0] dt;
        logic [3:0] de;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pr, input logic [1:0] k, input logic t, input logic [1:0] o,
                       input logic [3:0] l, input logic v, input logic p, input logic lg,
                       input logic [4:0] s, input logic [1:0] m, input logic [3:0] dt,
                       input logic [3:0] de, input logic ovf, input logic unf);
        vec_t r;
        r.pre_rst = pr; r.kind = k; r.tgt = t; r.opc = o; r.lutv = l; r.v = v; r.pop = p;
        r.legal = lg; r.strb = s; r.mux = m; r.dt = dt; r.de = de; r.ovf = ovf; r.unf = unf;
        tbl.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        instr_valid = 1'b0;
        err_clr     = 1'b0;
        tick();
        tick();
        chk("rst strb", 32'(strb), 32'd0);
        chk("rst depths", {depth_t, depth_e}, '0);
        chk("rst errs", {err_overflow, err_underflow}, 32'd0);
        chk("rst busy/done", {busy, done}, 32'd0);
        chk("rst ready", 32'(instr_ready), 32'd1);
        chk("rst cycle/op/lut/val/mux", {cycle, op, lut, val, mux_sta}, 32'd0);
        reset = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready wait", 32'(instr_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        int   n_done;
        int   n_rdy;
        int   n_strb;
        int   n_dd;
        logic prev_done;

        reset = 1'b1; instr_valid = 1'b0; err_clr = 1'b0;
        instr_kind = 2'b00; instr_tgt = 1'b0; instr_op = 2'b00;
        instr_lut = 4'h0; instr_val = 1'b0; instr_pop = 1'b0;

        add(1, K_PUSH, 1, 2'd0, 4'h0, 1, 0, 1, 5'b10010, 2'b00, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            add(0, K_PUSH, 0, 2'(i), 4'(i), i[0], 0, 1, 5'b10010, 2'b00, 1, 4'(i), 0, 0);
        add(0, K_PUSH, 0, 2'd0, 4'h0, 0, 0, 0, 5'b00000, 2'b00, 1, 6, 1, 0);
        add(1, K_LUT,  1, 2'd0, 4'h0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 1);
        add(0, K_PUSH, 1, 2'd0, 4'h0, 1, 0, 1, 5'b10010, 2'b00, 1, 0, 0, 1);
        add(0, K_PUSH, 1, 2'd0, 4'h0, 0, 0, 1, 5'b10010, 2'b00, 2, 0, 0, 1);
        add(0, K_LUT,  1, 2'b10, 4'b0110, 0, 1, 1, 5'b01011, 2'b10, 1, 0, 0, 1);
        add(0, K_LUT,  1, 2'd0, 4'h0, 0, 1, 0, 5'b00000, 2'b00, 1, 0, 0, 1);
        for (int i = 1; i <= 3; i++)
            add(0, K_PUSH, 0, 2'd1, 4'h3, 1, 0, 1, 5'b10010, 2'b00, 1, 4'(i), 0, 1);
        add(0, K_ACC,  0, 2'd1, 4'h3, 1, 0, 1, 5'b01110, 2'b11, 1, 4, 0, 1);
        add(0, K_ACC,  0, 2'd2, 4'h5, 0, 1, 1, 5'b01111, 2'b11, 1, 3, 0, 1);
        add(0, K_LUT,  0, 2'd1, 4'h9, 1, 0, 1, 5'b01010, 2'b10, 1, 3, 0, 1);
        add(0, K_END,  1, 2'd3, 4'hf, 1, 0, 1, 5'b00000, 2'b00, 1, 3, 0, 1);
        add(1, K_ACC,  0, 2'd0, 4'h0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++)
            add(0, K_PUSH, 0, 2'd2, 4'h4, 0, 0, 1, 5'b10010, 2'b00, 0, 4'(i), 0, 1);
        add(0, K_ACC,  0, 2'd0, 4'h0, 0, 0, 0, 5'b00000, 2'b00, 0, 6, 1, 1);
        add(0, K_ACC,  0, 2'd3, 4'ha, 0, 1, 1, 5'b01111, 2'b11, 0, 5, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.pre_rst) do_reset();
            wait_ready();
            instr_kind = v.kind; instr_tgt = v.tgt; instr_op = v.opc;
            instr_lut = v.lutv; instr_val = v.v; instr_pop = v.pop;
            instr_valid = 1'b1;
            sb.push_back(v);
            tick();
            instr_valid = 1'b0;
            e = sb.pop_front();
            if (e.legal) begin
                chk($sformatf("row%0d issue strb", i), 32'(strb), 32'(e.strb));
                chk($sformatf("row%0d issue mux", i), 32'(mux_sta), 32'(e.mux));
                chk($sformatf("row%0d issue cycle/op/lut/val", i), {cycle, op, lut, val},
                    {e.tgt, e.opc, e.lutv, e.v});
                chk($sformatf("row%0d issue ready/busy/done", i), {instr_ready, busy, done}, 32'b010);
                tick();
                chk($sformatf("row%0d hold strb", i), 32'(strb), 32'd0);
                chk($sformatf("row%0d hold done", i), 32'(done), 32'(e.kind == K_END));
                chk($sformatf("row%0d depth_t", i), 32'(depth_t), 32'(e.dt));
                chk($sformatf("row%0d depth_e", i), 32'(depth_e), 32'(e.de));
                tick();
                chk($sformatf("row%0d idle ready/busy/done", i), {instr_ready, busy, done}, 32'b100);
                chk($sformatf("row%0d idle held", i), {cycle, op, lut, val},
                    {e.tgt, e.opc, e.lutv, e.v});
            end else begin
                chk($sformatf("row%0d err strb", i), 32'(strb), 32'd0);
                chk($sformatf("row%0d err ready/busy", i), {instr_ready, busy}, 32'b01);
                chk($sformatf("row%0d err flags", i), {err_overflow, err_underflow}, {e.ovf, e.unf});
                tick();
                chk($sformatf("row%0d err stays", i), {instr_ready, 5'(strb)}, 32'd0);
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                chk($sformatf("row%0d cleared ready", i), 32'(instr_ready), 32'd1);
                chk($sformatf("row%0d err depths", i), {depth_t, depth_e}, {3'(e.dt), 3'(e.de)});
                chk($sformatf("row%0d sticky flags", i), {err_overflow, err_underflow}, {e.ovf, e.unf});
            end
        end

        // Reset asserted during the ISSUE clock of a PUSH aborts it.
        do_reset();
        instr_kind = K_PUSH; instr_tgt = 1'b1; instr_val = 1'b1; instr_op = 2'd2;
        instr_lut = 4'h7; instr_pop = 1'b0; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("abort issue seen", 32'(en_push_force), 32'd1);
        reset = 1'b0;
        tick();
        chk("abort strb", 32'(strb), 32'd0);
        chk("abort outputs", {cycle, op, lut, val, mux_sta, busy, done}, 32'd0);
        chk("abort depth_t", 32'(depth_t), 32'd0);
        chk("abort ready", 32'(instr_ready), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort after strb/depth", {5'(strb), depth_t, busy}, 32'd0);

        // Continuous END stream: accepted every third clock, one-clock done.
        do_reset();
        instr_kind = K_END; instr_tgt = 1'b0; instr_valid = 1'b1; err_clr = 1'b1;
        n_done = 0; n_rdy = 0; n_strb = 0; n_dd = 0; prev_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) n_done++;
            if (done && prev_done) n_dd++;
            if (instr_ready) n_rdy++;
            if (strb != 5'd0) n_strb++;
            prev_done = done;
        end
        instr_valid = 1'b0;
        err_clr = 1'b0;
        chk("stream done count", 32'(n_done), 32'd4);
        chk("stream ready count", 32'(n_rdy), 32'd4);
        chk("stream done width", 32'(n_dd), 32'd0);
        chk("stream strobes", 32'(n_strb), 32'd0);
        chk("stream depths", {depth_t, depth_e}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
